// File: rtl/jam_gen.sv
// Exhaustive assignment search: walks every job permutation in lexicographic
// order, summing Cost per permutation, and reports the optimum and its multiplicity.
module jam_gen #(
  parameter int N  = 8,
  parameter int CW = 7,
  parameter int MW = 4,
  localparam int IW = (N > 2) ? $clog2(N) : 1,
  localparam int SW = CW + 3
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  input  logic          MODE,
  output logic [IW-1:0] W,
  output logic [IW-1:0] J,
  input  logic [CW-1:0] Cost,
  output logic [MW-1:0] MatchCount,
  output logic [SW-1:0] MinCost,
  output logic          Valid,
  output logic          BUSY
);

  typedef enum logic [2:0] {IDLE, INIT, ACCUM, CMP, PERM, DONE} state_t;

  state_t        state_q;
  logic          mode_q;
  logic          pendStart_q;
  logic          pendMode_q;
  logic          first_q;
  logic          valid_q;
  logic          revPhase_q;
  logic [IW-1:0] perm_q [N];
  logic [IW-1:0] k_q;
  logic [IW-1:0] pivot_q;
  logic [SW-1:0] acc_q;
  logic [SW-1:0] minCost_q;
  logic [MW-1:0] matchCount_q;

  logic          isLast;
  logic          better;
  logic          equal;
  logic [IW-1:0] pivot_d;
  logic [IW-1:0] succ_d;
  logic [IW-1:0] permSwap_d [N];
  logic [IW-1:0] permRev_d [N];
  logic [SW-1:0] acc_d;

  always_comb begin
    isLast = 1'b1;
    for (int i = 0; i < N - 1; i++) begin
      if (perm_q[i] < perm_q[i+1]) isLast = 1'b0;
    end
  end

  // Pivot is the rightmost ascent; successor is the rightmost larger entry after it.
  always_comb begin
    pivot_d = '0;
    succ_d  = '0;
    for (int i = 0; i < N - 1; i++) begin
      if (perm_q[i] < perm_q[i+1]) pivot_d = IW'(i);
    end
    for (int j = 1; j < N; j++) begin
      if ((IW'(j) > pivot_d) && (perm_q[j] > perm_q[pivot_d])) succ_d = IW'(j);
    end
    for (int i = 0; i < N; i++) permSwap_d[i] = perm_q[i];
    permSwap_d[pivot_d] = perm_q[succ_d];
    permSwap_d[succ_d]  = perm_q[pivot_d];
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      permRev_d[i] = perm_q[i];
      if (IW'(i) > pivot_q) permRev_d[i] = perm_q[IW'(N + int'(pivot_q) - i)];
    end
  end

  assign acc_d  = acc_q + SW'(Cost);
  assign better = first_q || (mode_q ? (acc_q > minCost_q) : (acc_q < minCost_q));
  assign equal  = (acc_q == minCost_q);

  assign W          = (state_q == ACCUM) ? k_q : '0;
  assign J          = (state_q == ACCUM) ? perm_q[k_q] : '0;
  assign MatchCount = matchCount_q;
  assign MinCost    = minCost_q;
  assign Valid      = valid_q;
  assign BUSY       = (state_q != IDLE) && !((state_q == DONE) && !valid_q);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      mode_q       <= 1'b0;
      pendStart_q  <= 1'b0;
      pendMode_q   <= 1'b0;
      first_q      <= 1'b0;
      valid_q      <= 1'b0;
      revPhase_q   <= 1'b0;
      k_q          <= '0;
      pivot_q      <= '0;
      acc_q        <= '0;
      minCost_q    <= '0;
      matchCount_q <= '0;
      for (int i = 0; i < N; i++) perm_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (START) begin
            mode_q  <= MODE;
            state_q <= INIT;
          end
        end
        INIT: begin
          for (int i = 0; i < N; i++) perm_q[i] <= IW'(i);
          acc_q        <= '0;
          k_q          <= '0;
          minCost_q    <= '0;
          matchCount_q <= '0;
          first_q      <= 1'b1;
          state_q      <= ACCUM;
        end
        ACCUM: begin
          acc_q <= acc_d;
          if (k_q == IW'(N - 1)) begin
            k_q     <= '0;
            state_q <= CMP;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        CMP: begin
          if (better) begin
            minCost_q    <= acc_q;
            matchCount_q <= MW'(1);
            first_q      <= 1'b0;
          end else if (equal && (matchCount_q != '1)) begin
            matchCount_q <= matchCount_q + 1'b1;
          end
          if (isLast) begin
            state_q <= DONE;
            valid_q <= 1'b1;
          end else begin
            state_q    <= PERM;
            revPhase_q <= 1'b0;
          end
        end
        PERM: begin
          if (!revPhase_q) begin
            for (int i = 0; i < N; i++) perm_q[i] <= permSwap_d[i];
            pivot_q    <= pivot_d;
            revPhase_q <= 1'b1;
          end else begin
            for (int i = 0; i < N; i++) perm_q[i] <= permRev_d[i];
            acc_q      <= '0;
            k_q        <= '0;
            revPhase_q <= 1'b0;
            state_q    <= ACCUM;
          end
        end
        DONE: begin
          // A START seen during the Valid cycle is held and acted on one cycle later.
          if (valid_q) begin
            valid_q <= 1'b0;
            if (START) begin
              pendStart_q <= 1'b1;
              pendMode_q  <= MODE;
            end
          end else if (START || pendStart_q) begin
            mode_q      <= pendStart_q ? pendMode_q : MODE;
            pendStart_q <= 1'b0;
            state_q     <= INIT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jam_gen.sv
// Self-checking bench for jam_gen: three instances (N=2, N=3, N=5) driven from
// a shared clock/reset, with a table of directed searches plus corner-case sequences.
module tb_jam_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstN;
  logic start2, mode2, start3, mode3, start5, mode5;
  logic [0:0] w2, j2;
  logic [1:0] w3, j3;
  logic [2:0] w5, j5;
  logic [6:0] cost2, cost3, cost5;
  logic [6:0] mat2 [2][2];
  logic [6:0] mat3 [3][3];
  logic [6:0] mat5 [5][5];
  logic [3:0] mc2, mc3, mc5;
  logic [9:0] min2, min3, min5;
  logic valid2, valid3, valid5, busy2, busy3, busy5;

  assign cost2 = mat2[w2][j2];
  assign cost3 = mat3[w3][j3];
  assign cost5 = mat5[w5][j5];

  jam_gen #(.N(2)) dut2 (.CLK(clk), .RST_N(rstN), .START(start2), .MODE(mode2), .W(w2), .J(j2),
    .Cost(cost2), .MatchCount(mc2), .MinCost(min2), .Valid(valid2), .BUSY(busy2));
  jam_gen #(.N(3)) dut3 (.CLK(clk), .RST_N(rstN), .START(start3), .MODE(mode3), .W(w3), .J(j3),
    .Cost(cost3), .MatchCount(mc3), .MinCost(min3), .Valid(valid3), .BUSY(busy3));
  jam_gen #(.N(5)) dut5 (.CLK(clk), .RST_N(rstN), .START(start5), .MODE(mode5), .W(w5), .J(j5),
    .Cost(cost5), .MatchCount(mc5), .MinCost(min5), .Valid(valid5), .BUSY(busy5));

  int testsRun = 0;
  int testsFailed = 0;
  int validCount2 = 0, validCount3 = 0, validCount5 = 0;
  int traceCount = 0, traceErr = 0, traceBase = 0;
  logic [1:0] wH1 = '0, wH2 = '0, jH1 = '0, jH2 = '0;

  function automatic logic [5:0] lexCodeOf(int idx);
    case (idx)
      0: return 6'b00_01_10;
      1: return 6'b00_10_01;
      2: return 6'b01_00_10;
      3: return 6'b01_10_00;
      4: return 6'b10_00_01;
      default: return 6'b10_01_00;
    endcase
  endfunction

  // Counts Valid pulses and rebuilds each N=3 permutation from the W/J trace.
  always @(negedge clk) begin
    if (valid2) validCount2 <= validCount2 + 1;
    if (valid3) validCount3 <= validCount3 + 1;
    if (valid5) validCount5 <= validCount5 + 1;
    if (w3 == 2'd2 && wH1 == 2'd1 && wH2 == 2'd0) begin
      if ({jH2, jH1, j3} != lexCodeOf((traceCount - traceBase) % 6)) traceErr <= traceErr + 1;
      traceCount <= traceCount + 1;
    end
    wH1 <= w3;
    wH2 <= wH1;
    jH1 <= j3;
    jH2 <= jH1;
  end

  function automatic int sizeOf(int inst);
    return (inst == 0) ? 2 : (inst == 1) ? 3 : 5;
  endfunction

  function automatic int specBound(int inst);
    int n = sizeOf(inst);
    int f = 1;
    for (int i = 2; i <= n; i++) f = f * i;
    return f * (2 * n + 4) + 4;
  endfunction

  function automatic int costVal(int id, int w, int j);
    case (id)
      0: return w * 2 + j + 1;
      1: return (w == j) ? 0 : 9;
      2: return w * 3 + j + 1;
      3: return (w == j) ? 3 : (j == (w + 1) % 3) ? 1 : 2;
      4: return 5;
      5: return 127;
      default: return (w == j) ? 10 : 0;
    endcase
  endfunction

  function automatic int validOf(int inst);
    case (inst) 0: return int'(valid2); 1: return int'(valid3); default: return int'(valid5); endcase
  endfunction
  function automatic int busyOf(int inst);
    case (inst) 0: return int'(busy2); 1: return int'(busy3); default: return int'(busy5); endcase
  endfunction
  function automatic int minOf(int inst);
    case (inst) 0: return int'(min2); 1: return int'(min3); default: return int'(min5); endcase
  endfunction
  function automatic int mcOf(int inst);
    case (inst) 0: return int'(mc2); 1: return int'(mc3); default: return int'(mc5); endcase
  endfunction
  function automatic int wjOf(int inst);
    case (inst) 0: return int'({w2, j2}); 1: return int'({w3, j3}); default: return int'({w5, j5}); endcase
  endfunction
  function automatic int vcOf(int inst);
    case (inst) 0: return validCount2; 1: return validCount3; default: return validCount5; endcase
  endfunction

  task automatic checkOutput(input string name, input int got, input int exp);
    testsRun++;
    if (got != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic setStart(input int inst, input logic s, input logic m);
    case (inst)
      0: begin start2 = s; mode2 = m; end
      1: begin start3 = s; mode3 = m; end
      default: begin start5 = s; mode5 = m; end
    endcase
  endtask

  task automatic loadMatrix(input int inst, input int id);
    for (int w = 0; w < sizeOf(inst); w++)
      for (int j = 0; j < sizeOf(inst); j++)
        case (inst)
          0: mat2[w][j] = 7'(costVal(id, w, j));
          1: mat3[w][j] = 7'(costVal(id, w, j));
          default: mat5[w][j] = 7'(costVal(id, w, j));
        endcase
  endtask

  task automatic waitValid(input int inst, output int cycles, output bit ok);
    int limit = 2 * specBound(inst);
    cycles = 1;
    ok = 1'b0;
    while (cycles < limit) begin
      if (validOf(inst) != 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      cycles++;
    end
  endtask

  // Pulses START for one edge, then flips MODE so a late change would show up.
  task automatic applyStimulus(input int inst, input bit md, output int cycles, output bit ok);
    @(negedge clk);
    setStart(inst, 1'b1, md);
    @(negedge clk);
    setStart(inst, 1'b0, ~md);
    checkOutput($sformatf("i%0d_busy_after_start", inst), busyOf(inst), 1);
    waitValid(inst, cycles, ok);
  endtask

  typedef struct {
    int inst;
    bit mode;
    int matId;
    int expMin;
    int expCnt;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int cycles, n, vcB, baseB, errB;
    bit ok;

    vecs[0]  = '{0, 1'b0, 0, 5, 2};
    vecs[1]  = '{0, 1'b1, 0, 5, 2};
    vecs[2]  = '{1, 1'b0, 1, 0, 1};
    vecs[3]  = '{1, 1'b1, 1, 27, 2};
    vecs[4]  = '{1, 1'b0, 2, 15, 6};
    vecs[5]  = '{1, 1'b0, 3, 3, 1};
    vecs[6]  = '{1, 1'b1, 3, 9, 1};
    vecs[7]  = '{2, 1'b0, 4, 25, 15};
    vecs[8]  = '{2, 1'b1, 5, 635, 15};
    vecs[9]  = '{2, 1'b1, 6, 50, 1};
    vecs[10] = '{2, 1'b0, 6, 0, 15};

    rstN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      setStart(i, 1'b0, 1'b0);
      loadMatrix(i, 0);
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("i%0d_reset_wj", i), wjOf(i), 0);
      checkOutput($sformatf("i%0d_reset_min", i), minOf(i), 0);
      checkOutput($sformatf("i%0d_reset_mc", i), mcOf(i), 0);
      checkOutput($sformatf("i%0d_reset_valid", i), validOf(i), 0);
      checkOutput($sformatf("i%0d_reset_busy", i), busyOf(i), 0);
    end
    #20;
    @(negedge clk);
    rstN = 1'b1;

    for (int v = 0; v < 11; v++) begin
      loadMatrix(vecs[v].inst, vecs[v].matId);
      vcB = vcOf(vecs[v].inst);
      applyStimulus(vecs[v].inst, vecs[v].mode, cycles, ok);
      checkOutput($sformatf("v%0d_valid_seen", v), int'(ok), 1);
      checkOutput($sformatf("v%0d_min", v), minOf(vecs[v].inst), vecs[v].expMin);
      checkOutput($sformatf("v%0d_count", v), mcOf(vecs[v].inst), vecs[v].expCnt);
      checkOutput($sformatf("v%0d_busy_in_valid", v), busyOf(vecs[v].inst), 1);
      checkOutput($sformatf("v%0d_latency_ok", v), int'(cycles <= specBound(vecs[v].inst)), 1);
      @(negedge clk);
      checkOutput($sformatf("v%0d_valid_one_cycle", v), validOf(vecs[v].inst), 0);
      repeat (2) @(negedge clk);
      checkOutput($sformatf("v%0d_min_hold", v), minOf(vecs[v].inst), vecs[v].expMin);
      checkOutput($sformatf("v%0d_busy_done", v), busyOf(vecs[v].inst), 0);
      checkOutput($sformatf("v%0d_valid_pulses", v), vcOf(vecs[v].inst) - vcB, 1);
    end

    // Reset asserted during the third permutation's accumulation.
    loadMatrix(1, 3);
    baseB = traceCount;
    @(negedge clk);
    setStart(1, 1'b1, 1'b0);
    @(negedge clk);
    setStart(1, 1'b0, 1'b0);
    n = 0;
    while (!((traceCount - baseB) >= 2 && w3 == 2'd1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rst_reach_third_perm", int'(n < 200), 1);
    checkOutput("rst_min_before", int'(min3), 6);
    #2 rstN = 1'b0;
    #1;
    checkOutput("rst_async_wj", int'({w3, j3}), 0);
    checkOutput("rst_async_min", int'(min3), 0);
    checkOutput("rst_async_mc", int'(mc3), 0);
    checkOutput("rst_async_busy", int'(busy3), 0);
    checkOutput("rst_async_valid", int'(valid3), 0);
    vcB = validCount3;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("rst_no_valid", validCount3 - vcB, 0);
    checkOutput("rst_idle_busy", int'(busy3), 0);

    loadMatrix(0, 0);
    applyStimulus(0, 1'b0, cycles, ok);
    checkOutput("restart_valid_seen", int'(ok), 1);
    checkOutput("restart_min", int'(min2), 5);
    checkOutput("restart_count", int'(mc2), 2);

    traceBase = traceCount;
    errB = traceErr;
    applyStimulus(1, 1'b0, cycles, ok);
    checkOutput("restart3_min", int'(min3), 3);
    checkOutput("restart3_count", int'(mc3), 1);
    repeat (3) @(negedge clk);
    checkOutput("restart3_trace_perms", traceCount - traceBase, 6);
    checkOutput("restart3_trace_order_errs", traceErr - errB, 0);

    // START pulsed mid-search with the opposite MODE must be ignored.
    loadMatrix(1, 1);
    traceBase = traceCount;
    errB = traceErr;
    vcB = validCount3;
    @(negedge clk);
    setStart(1, 1'b1, 1'b0);
    @(negedge clk);
    setStart(1, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    setStart(1, 1'b1, 1'b1);
    checkOutput("busy_start_busy", int'(busy3), 1);
    @(negedge clk);
    setStart(1, 1'b0, 1'b1);
    waitValid(1, cycles, ok);
    checkOutput("busy_start_valid_seen", int'(ok), 1);
    checkOutput("busy_start_min", int'(min3), 0);
    checkOutput("busy_start_count", int'(mc3), 1);
    repeat (20) @(negedge clk);
    checkOutput("busy_start_pulses", validCount3 - vcB, 1);
    checkOutput("busy_start_trace_perms", traceCount - traceBase, 6);
    checkOutput("busy_start_trace_order_errs", traceErr - errB, 0);

    // START during the Valid cycle is honoured one cycle later.
    loadMatrix(0, 0);
    vcB = validCount2;
    applyStimulus(0, 1'b1, cycles, ok);
    checkOutput("vstart_first_valid", int'(ok), 1);
    setStart(0, 1'b1, 1'b0);
    @(negedge clk);
    setStart(0, 1'b0, 1'b0);
    checkOutput("vstart_gap_valid", int'(valid2), 0);
    @(negedge clk);
    checkOutput("vstart_rerun_busy", int'(busy2), 1);
    waitValid(0, cycles, ok);
    checkOutput("vstart_second_valid", int'(ok), 1);
    checkOutput("vstart_min", int'(min2), 5);
    checkOutput("vstart_count", int'(mc2), 2);
    repeat (3) @(negedge clk);
    checkOutput("vstart_pulses", validCount2 - vcB, 2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/jam_gen.md
JAM_GEN -- requirements
Module: jam_gen

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter N, default 8, SHALL set the number of workers and jobs; legal range 2..8.
REQ-003 Parameter CW, default 7, SHALL set the width of one Cost entry.
REQ-004 Parameter MW, default 4, SHALL set the MatchCount width.
REQ-005 Derived localparam IW = max(1, clog2(N)) SHALL size W and J; SW = CW+3 SHALL size MinCost (10 at default).
REQ-006 Port CLK, input, 1 bit: rising-edge clock.
REQ-007 Port RST_N, input, 1 bit: asynchronous active-low reset.
REQ-008 Port START, input, 1 bit: sampled high in IDLE or DONE begins a search.
REQ-009 Port MODE, input, 1 bit: 0 = minimum-cost search, 1 = maximum-cost search; latched at START.
REQ-010 Port W, output, IW bits: worker index of the current cost lookup.
REQ-011 Port J, output, IW bits: job index of the current cost lookup.
REQ-012 Port Cost, input, CW bits: cost of (W,J), valid combinationally in the same cycle and sampled at the next rising edge.
REQ-013 Port MatchCount, output, MW bits: number of assignments that reach the optimum.
REQ-014 Port MinCost, output, SW bits: optimum total cost (minimum or maximum per MODE).
REQ-015 Port Valid, output, 1 bit: one-cycle pulse when results are final.
REQ-016 Port BUSY, output, 1 bit: high from START acceptance until the Valid cycle, inclusive.

Function
REQ-017 The FSM SHALL have states IDLE, INIT, ACCUM, CMP, PERM, DONE.
REQ-018 IDLE/DONE -> INIT on START=1; INIT loads perm[i]=i, clears the accumulator, MatchCount and MinCost, and sets a first-flag.
REQ-019 INIT -> ACCUM; ACCUM SHALL run exactly N cycles, driving W=k, J=perm[k] for k=0..N-1 and adding Cost to an SW-bit accumulator each cycle.
REQ-020 ACCUM -> CMP: on first-flag, or on sum strictly better (less if MODE=0, greater if MODE=1), MinCost<=sum and MatchCount<=1.
REQ-021 In CMP, sum equal to MinCost SHALL increment MatchCount, saturating at 2^MW-1; a worse sum changes nothing.
REQ-022 CMP -> PERM unless perm is the last lexicographic permutation (strictly descending), in which case CMP -> DONE.
REQ-023 PERM SHALL produce the lexicographic next permutation (pivot search, successor swap, suffix reversal) in at most N+2 cycles, then go to ACCUM with the accumulator cleared.
REQ-024 All N! permutations SHALL be evaluated exactly once; total START-to-Valid latency SHALL NOT exceed N!*(2N+4)+4 cycles.
REQ-025 Valid SHALL be high for exactly the first DONE cycle; MinCost and MatchCount SHALL hold until the next INIT.
REQ-026 START while BUSY=1 SHALL be ignored; START in the Valid cycle SHALL be honoured on the next DONE cycle.
REQ-027 W and J SHALL be 0 outside ACCUM; MODE changes after acceptance SHALL have no effect.
REQ-028 The accumulator SHALL NOT overflow: N*(2^CW-1) fits in SW bits for N<=8.

Reset
REQ-029 RST_N low SHALL immediately force state IDLE, W=0, J=0, MatchCount=0, MinCost=0, Valid=0, BUSY=0, perm cleared.
REQ-030 Reset asserted mid-search SHALL abandon the search with no Valid pulse; the next START after release SHALL begin a fresh search.

Verification
REQ-031 N=2, Cost[w][j] = {{1,2},{3,4}}, MODE=0 -> Valid with MinCost=5, MatchCount=2.
REQ-032 N=3, Cost=0 on diagonal and 9 elsewhere, MODE=0 -> MinCost=0, MatchCount=1; same matrix with MODE=1 -> MinCost=27, MatchCount=2.
REQ-033 N=8, all Cost=5, MODE=0 -> MinCost=40, MatchCount=15 (saturated), latency within the REQ-024 bound.
REQ-034 N=8, all Cost=127, MODE=1 -> MinCost=1016, MatchCount=15, no overflow.
REQ-035 RST_N pulsed low during ACCUM of the 3rd permutation -> all outputs 0 asynchronously and no Valid; a restarted run then matches REQ-031 results.
REQ-036 START pulsed while BUSY=1 -> ignored, exactly one Valid pulse; W/J trace shows every permutation visited once in lexicographic order.
